// File: rtl/axi_read_arbiter_if.sv
// Bundle between NUM_REQ read requesters, the arbiter, and the shared read target.
// Requester, target and status signals share one interface; the arbiter uses the slave modport.
interface axi_read_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_arvalid;
    logic [8*NUM_REQ-1:0] req_arlen;
    logic [NUM_REQ-1:0]   req_arready;
    logic [NUM_REQ-1:0]   req_rvalid;
    logic [NUM_REQ-1:0]   req_rlast;
    logic [NUM_REQ-1:0]   req_rready;

    logic                 tgt_arvalid;
    logic [7:0]           tgt_arlen;
    logic                 tgt_rready;
    logic                 tgt_arready;
    logic                 tgt_rvalid;
    logic                 tgt_rlast;

    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 protocol_err;

    modport slave (
        input  req_arvalid, req_arlen, req_rready,
        input  tgt_arready, tgt_rvalid, tgt_rlast,
        output req_arready, req_rvalid, req_rlast,
        output tgt_arvalid, tgt_arlen, tgt_rready,
        output grant, busy, protocol_err
    );

    modport master (
        output req_arvalid, req_arlen, req_rready,
        output tgt_arready, tgt_rvalid, tgt_rlast,
        input  req_arready, req_rvalid, req_rlast,
        input  tgt_arvalid, tgt_arlen, tgt_rready,
        input  grant, busy, protocol_err
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one read target among NUM_REQ requesters, one burst per grant.
// Handshakes are routed combinationally; burst length is checked against arlen.
module axi_read_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic clk,
    input  logic rst_n,
    axi_read_arbiter_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned BEAT_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               err_q, err_d;

    logic               arv_sel;
    logic               rrdy_sel;
    logic [LEN_W-1:0]   arlen_sel;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;

    // State register and burst bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            beat_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // Requester signals of the current owner
    always_comb begin
        arv_sel   = 1'b0;
        rrdy_sel  = 1'b0;
        arlen_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                arv_sel   = bus.req_arvalid[i];
                rrdy_sel  = bus.req_rready[i];
                arlen_sel = bus.req_arlen[8*i +: 8];
            end
        end
    end

    // Round-robin search starting just after the previous owner
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            int unsigned c;
            c = 32'(last_q) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!win_valid && bus.req_arvalid[IDX_W'(c)]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
    end

    // Next-state and bookkeeping updates
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        beat_d  = beat_q;
        len_d   = len_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    gidx_d  = win_idx;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (arv_sel && bus.tgt_arready) begin
                    len_d   = arlen_sel;
                    beat_d  = '0;
                    state_d = ST_DATA;
                end else if (!arv_sel) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bus.tgt_rvalid && rrdy_sel) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (bus.tgt_rlast) begin
                        if (beat_q != {1'b0, len_q}) err_d = 1'b1;
                        last_d  = gidx_q;
                        state_d = ST_IDLE;
                    end else if (beat_q == {1'b0, len_q}) begin
                        // Beat beyond the announced length; keep forwarding until rlast
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake routing and status outputs
    always_comb begin
        bus.req_arready  = '0;
        bus.req_rvalid   = '0;
        bus.req_rlast    = '0;
        bus.tgt_arvalid  = 1'b0;
        bus.tgt_arlen    = '0;
        bus.tgt_rready   = 1'b0;
        bus.grant        = '0;
        bus.busy         = 1'b0;
        bus.protocol_err = err_q;
        case (state_q)
            ST_ADDR: begin
                bus.tgt_arvalid         = arv_sel;
                bus.tgt_arlen           = arlen_sel;
                bus.req_arready[gidx_q] = bus.tgt_arready;
                bus.grant               = NUM_REQ'(1) << gidx_q;
                bus.busy                = 1'b1;
            end
            ST_DATA: begin
                bus.req_rvalid[gidx_q] = bus.tgt_rvalid;
                bus.req_rlast[gidx_q]  = bus.tgt_rvalid & bus.tgt_rlast;
                bus.tgt_rready         = rrdy_sel;
                bus.grant              = NUM_REQ'(1) << gidx_q;
                bus.busy               = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
